// File: rtl/haze_regfile_pkg.sv
// Shared types and constants for the haze-cpu architectural register file.
package haze_regfile_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } dump_state_t;

   localparam int REG_ZERO = 0;

endpackage

// File: rtl/register_file_dump.sv
// Dump engine: walks every register index and offers one {index, data} beat per
// handshake. Storage is read through the bypassed port supplied by the parent.
module register_file_dump
   import haze_regfile_pkg::*;
#(
   parameter int  N = 32,
   parameter int  R = 32,
   localparam int A = $clog2(R)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        ready,
   output logic [A-1:0] read_index,
   input  logic [N-1:0] read_data,
   output dump_state_t  state,
   output logic [A-1:0] index,
   output logic [N-1:0] data,
   output logic         done
);

   // Look one entry ahead so the next beat is captured on the accepting edge.
   assign read_index = index + A'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         index <= '0;
         data  <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SEND;
                  index <= '0;
                  data  <= '0;
               end
            end
            SEND: begin
               if (ready) begin
                  if (index == A'(R - 1)) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else begin
                     index <= read_index;
                     data  <= read_data;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/register_file.sv
// Architectural register file: R x N storage, x0 hardwired to zero, two
// write-through read ports and a valid/ready dump stream for debug readback.
module register_file
   import haze_regfile_pkg::*;
#(
   parameter int  N = 32,
   parameter int  R = 32,
   localparam int A = $clog2(R)
) (
   input  logic         i_Clock,
   input  logic         i_Reset,
   input  logic         i_WriteEnable,
   input  logic [A-1:0] i_WriteAddress,
   input  logic [N-1:0] i_WriteData,
   input  logic [A-1:0] i_ReadAddressA,
   output logic [N-1:0] o_ReadDataA,
   input  logic [A-1:0] i_ReadAddressB,
   output logic [N-1:0] o_ReadDataB,
   input  logic         i_DumpStart,
   output logic         o_DumpValid,
   input  logic         i_DumpReady,
   output logic [A-1:0] o_DumpIndex,
   output logic [N-1:0] o_DumpData,
   output logic         o_DumpDone
);

   // Dump handshake: a beat transfers on any rising edge where o_DumpValid and
   // i_DumpReady are both high; index and data stay frozen until that happens.

   logic [N-1:0] regs [R];
   logic [A-1:0] dump_read_index;
   logic [N-1:0] dump_read_data;
   dump_state_t  dump_state;

   always_ff @(posedge i_Clock) begin
      if (!i_Reset) begin
         for (int i = 0; i < R; i++) regs[i] <= '0;
      end else if (i_WriteEnable && (i_WriteAddress != A'(REG_ZERO))) begin
         regs[i_WriteAddress] <= i_WriteData;
      end
   end

   function automatic logic [N-1:0] bypass_read(
      input logic [A-1:0] addr,
      input logic         we,
      input logic [A-1:0] waddr,
      input logic [N-1:0] wdata,
      input logic [N-1:0] stored
   );
      if (addr == A'(REG_ZERO)) return '0;
      else if (we && (waddr == addr)) return wdata;
      else return stored;
   endfunction

   assign o_ReadDataA = bypass_read(i_ReadAddressA, i_WriteEnable, i_WriteAddress,
                                    i_WriteData, regs[i_ReadAddressA]);
   assign o_ReadDataB = bypass_read(i_ReadAddressB, i_WriteEnable, i_WriteAddress,
                                    i_WriteData, regs[i_ReadAddressB]);
   assign dump_read_data = bypass_read(dump_read_index, i_WriteEnable, i_WriteAddress,
                                       i_WriteData, regs[dump_read_index]);

   register_file_dump #(.N(N), .R(R)) u_dump (
      .clk        (i_Clock),
      .rst_n      (i_Reset),
      .start      (i_DumpStart),
      .ready      (i_DumpReady),
      .read_index (dump_read_index),
      .read_data  (dump_read_data),
      .state      (dump_state),
      .index      (o_DumpIndex),
      .data       (o_DumpData),
      .done       (o_DumpDone)
   );

   assign o_DumpValid = (dump_state == SEND);

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: port reads, bypass, x0 and dump streaming
// checked against a bench-side register model and an expected-beat queue.
module tb_register_file;

   localparam int N = 32;
   localparam int R = 32;
   localparam int A = $clog2(R);

   logic         clk = 1'b0;
   logic         rst_n;
   logic         we;
   logic [A-1:0] waddr;
   logic [N-1:0] wdata;
   logic [A-1:0] ra;
   logic [N-1:0] rd_a;
   logic [A-1:0] rb;
   logic [N-1:0] rd_b;
   logic         start;
   logic         valid;
   logic         ready;
   logic [A-1:0] dindex;
   logic [N-1:0] ddata;
   logic         done;

   int checks = 0;
   int errors = 0;

   logic [N-1:0]   model [R];
   logic [A+N-1:0] exp_q [$];

   register_file dut (
      .i_Clock        (clk),
      .i_Reset        (rst_n),
      .i_WriteEnable  (we),
      .i_WriteAddress (waddr),
      .i_WriteData    (wdata),
      .i_ReadAddressA (ra),
      .o_ReadDataA    (rd_a),
      .i_ReadAddressB (rb),
      .o_ReadDataB    (rd_b),
      .i_DumpStart    (start),
      .o_DumpValid    (valid),
      .i_DumpReady    (ready),
      .o_DumpIndex    (dindex),
      .o_DumpData     (ddata),
      .o_DumpDone     (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_reg(input int addr, input logic [N-1:0] value);
      we    = 1'b1;
      waddr = A'(addr);
      wdata = value;
      tick();
      we = 1'b0;
      if (addr != 0) model[addr] = value;
   endtask

   // mode 0: ready high; 1: ready 1,0,0 repeating; 2: stall at beat 9 with a
   // write to x9; 3: reset while beat 12 is offered.
   task automatic run_dump(input int mode, input bit hold_start);
      int k = 0;
      int beats = 0;
      int lows = 0;
      int stall = 0;
      bit aborted = 0;
      exp_q.delete();
      for (int i = 0; i < R; i++) exp_q.push_back({A'(i), model[i]});
      start = 1'b1;
      tick();
      if (!hold_start) start = 1'b0;
      while (exp_q.size() > 0 && k < 400) begin
         we = 1'b0;
         case (mode)
            1: ready = (k % 3 == 0);
            2: begin
               ready = !(beats == 9 && stall < 3);
               if (beats == 9 && stall == 0) begin
                  we    = 1'b1;
                  waddr = A'(9);
                  wdata = 32'h99;
                  model[9] = 32'h99;
               end
               if (beats == 9) stall++;
            end
            3: begin
               ready = 1'b1;
               if (beats == 12) begin
                  check("pre_reset_index", 64'(dindex), 64'd12);
                  rst_n = 1'b0;
                  tick();
                  #1;
                  check("reset_mid_valid", 64'(valid), 64'd0);
                  check("reset_mid_done", 64'(done), 64'd0);
                  rst_n = 1'b1;
                  for (int i = 0; i < R; i++) model[i] = '0;
                  exp_q.delete();
                  aborted = 1;
                  break;
               end
            end
            default: ready = 1'b1;
         endcase
         #1;
         check("dump_valid", 64'(valid), 64'd1);
         check("done_early", 64'(done), 64'd0);
         check("beat", 64'({dindex, ddata}), 64'(exp_q[0]));
         if (ready) begin
            void'(exp_q.pop_front());
            beats++;
         end else begin
            lows++;
         end
         tick();
         k++;
      end
      we = 1'b0;
      ready = 1'b1;
      if (!aborted) begin
         check("dump_beats_left", 64'(exp_q.size()), 64'd0);
         #1;
         check("done_pulse", 64'(done), 64'd1);
         check("done_valid_low", 64'(valid), 64'd0);
         check("dump_cycles", 64'(k), 64'(R + lows));
         start = 1'b0;
         tick();
         #1;
         check("done_one_cycle", 64'(done), 64'd0);
         check("idle_after_done", 64'(valid), 64'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      we = 1'b0; waddr = '0; wdata = '0;
      ra = '0; rb = '0;
      start = 1'b0; ready = 1'b1;
      for (int i = 0; i < R; i++) model[i] = '0;
      tick();
      tick();
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_index", 64'(dindex), 64'd0);
      check("rst_data", 64'(ddata), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      rst_n = 1'b1;

      ra = A'(5); rb = A'(0);
      #1;
      check("rst_read_a5", 64'(rd_a), 64'd0);
      check("rst_read_b0", 64'(rd_b), 64'd0);
      run_dump(0, 0);

      write_reg(7, 32'hDEADBEEF);
      ra = A'(7);
      #1;
      check("read_x7", 64'(rd_a), 64'hDEADBEEF);
      write_reg(0, 32'h1234);
      rb = A'(0);
      #1;
      check("read_x0", 64'(rd_b), 64'd0);

      // Same-cycle write-through on both ports.
      we = 1'b1; waddr = A'(3); wdata = 32'hA5A5A5A5;
      ra = A'(3); rb = A'(3);
      #1;
      check("bypass_a", 64'(rd_a), 64'hA5A5A5A5);
      check("bypass_b", 64'(rd_b), 64'hA5A5A5A5);
      waddr = A'(0); wdata = 32'h5555; ra = A'(0);
      #1;
      check("bypass_x0", 64'(rd_a), 64'd0);
      check("no_bypass_other", 64'(rd_b), 64'd0);
      waddr = A'(3); wdata = 32'hA5A5A5A5;
      tick();
      model[3] = 32'hA5A5A5A5;
      we = 1'b0;
      ra = A'(3); rb = A'(7);
      #1;
      check("stored_x3", 64'(rd_a), 64'hA5A5A5A5);
      check("stored_x7", 64'(rd_b), 64'hDEADBEEF);

      for (int i = 1; i < R; i++) write_reg(i, 32'(i * 32'h11));
      for (int i = 0; i < R; i++) begin
         ra = A'(i); rb = A'(R - 1 - i);
         #1;
         check("fill_read_a", 64'(rd_a), 64'(model[i]));
         check("fill_read_b", 64'(rd_b), 64'(model[R - 1 - i]));
      end

      run_dump(1, 0);
      run_dump(2, 0);
      ra = A'(9);
      #1;
      check("x9_after_stall", 64'(rd_a), 64'h99);

      run_dump(3, 0);
      for (int i = 0; i < R; i++) begin
         ra = A'(i); rb = A'(i);
         #1;
         check("post_reset_a", 64'(rd_a), 64'd0);
         check("post_reset_b", 64'(rd_b), 64'd0);
      end
      tick();
      // Start held through the whole dump: ignored in SEND and at the done edge.
      run_dump(0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_file.md
# register_file

Architectural integer register file for the haze-cpu core: R entries of N bits, one write port, two combinational read ports for decode/operand fetch. Register 0 is hardwired to zero. A sequential dump engine streams every entry out over a valid/ready handshake for debug and test readback. It sits between writeback (the writer) and decode plus the debug unit (the readers).

## Interface
- N, 32, data width per register
- R, 32, number of registers; power of two, ≥ 2
- A, $clog2(R), address width; derived, not overridden
- i_Clock  in  1  single clock; all state updates on rising edge
- i_Reset  in  1  reset, synchronous, active-low (0 = reset)
- i_WriteEnable  in  1  commit i_WriteData to i_WriteAddress this edge
- i_WriteAddress  in  A  write index
- i_WriteData  in  N  write value
- i_ReadAddressA  in  A  read port A index
- o_ReadDataA  out  N  read port A value, combinational
- i_ReadAddressB  in  A  read port B index
- o_ReadDataB  out  N  read port B value, combinational
- i_DumpStart  in  1  request full dump; sampled only in IDLE
- o_DumpValid  out  1  dump beat present
- i_DumpReady  in  1  consumer accepts beat
- o_DumpIndex  out  A  register index of current beat
- o_DumpData  out  N  register value of current beat
- o_DumpDone  out  1  one-cycle pulse after final beat accepted

## Operation
- Reset (i_Reset low at edge): all entries ← 0, dump FSM → IDLE, o_DumpValid 0, o_DumpIndex 0, o_DumpData 0, o_DumpDone 0. Reset wins over any write or handshake that edge.
- Write: i_WriteEnable=1 and i_WriteAddress≠0 → entry updated at edge. Writes to index 0 are discarded.
- Read: index 0 → 0. Otherwise, if i_WriteEnable=1 and i_WriteAddress equals the read index, output i_WriteData (write-through bypass); else stored value. Both ports independent; same index on both is legal.
- Dump FSM states: IDLE, SEND.
  - IDLE: i_DumpStart=1 → SEND, index ← 0, data ← 0 (entry 0).
  - SEND: o_DumpValid=1. Beat accepted when i_DumpReady=1. On accept with index<R-1: index ← index+1, data ← that entry's value with bypass rule applied. On accept with index=R-1: → IDLE, o_DumpDone=1 for one cycle.
  - i_DumpStart in SEND ignored. o_DumpIndex/o_DumpData stable while valid && !ready; a write to the held index after capture is not reflected in the held beat.
  - In IDLE, o_DumpIndex/o_DumpData hold last values.

## Timing
- Read ports: zero latency, combinational from addresses, write port and storage.
- Write visible at read ports in the same cycle via bypass, from storage thereafter.
- Dump: i_DumpStart high at edge t → o_DumpValid high after t, index 0. With ready held high: index k during cycle t+1+k; final beat (R-1) accepted at edge t+R; o_DumpDone high, o_DumpValid low during cycle t+R+1 only.
- Ready low for m cycles stretches the dump by exactly m.
- i_DumpStart coincident with the done edge is ignored (FSM was in SEND); a new dump needs start while IDLE.
- Reset mid-dump: o_DumpValid low, no o_DumpDone, next cycle.

## Structure
- Package haze_regfile_pkg: dump_state_t enum {IDLE, SEND}; constant REG_ZERO = 0.
- Sub-module register_file_dump: FSM, index counter, captured data register and handshake; it reads storage through a bypassed read-port-style interface supplied by the top. Storage and read/bypass logic live in register_file.

## Test plan
- Reset, then read A=5, B=0 → both 0; dump with ready high → 32 beats, all data 0, o_DumpDone at cycle t+33.
- Write x7=0xDEADBEEF, next cycle read A=7 → 0xDEADBEEF; write x0=0x1234, read B=0 → 0.
- Same-cycle bypass: write x3=0xA5A5A5A5 while A=3, B=3 → both 0xA5A5A5A5 that cycle; stored old value not shown.
- Dump with i_DumpReady toggling 1,0,0,1…, x1..x31 = index×0x11 → beats in order 0..31, correct values, held stable while ready low, done once.
- Hold dump at index 9 (ready low), write x9=0x99 → beat still shows old x9; release → next beat x10 unaffected.
- Assert reset at index 12 of a dump → o_DumpValid 0 next cycle, no done pulse, all entries 0, new i_DumpStart begins at index 0.
